// File: rtl/riscv_core_mem_arbiter.sv
// Round-robin line-transfer arbiter between the I-cache and D-cache.
// It serialises one BEATS-beat burst at a time onto a single memory port.
module riscv_core_mem_arbiter #(
    parameter int BEATS  = 4,
    parameter int DATA_W = 64,
    parameter int ADDR_W = 64
) (
    input  logic                       i_mem_arbiter_clk,
    input  logic                       i_mem_arbiter_rst_n,
    input  logic                       i_mem_arbiter_icache_req,
    input  logic [ADDR_W-1:0]          i_mem_arbiter_icache_addr,
    input  logic                       i_mem_arbiter_dcache_req,
    input  logic                       i_mem_arbiter_dcache_we,
    input  logic [ADDR_W-1:0]          i_mem_arbiter_dcache_addr,
    input  logic [DATA_W-1:0]          i_mem_arbiter_dcache_wdata,
    input  logic                       i_mem_arbiter_mem_ack,
    input  logic [DATA_W-1:0]          i_mem_arbiter_mem_rdata,
    output logic                       o_mem_arbiter_mem_req,
    output logic                       o_mem_arbiter_mem_we,
    output logic [ADDR_W-1:0]          o_mem_arbiter_mem_addr,
    output logic [DATA_W-1:0]          o_mem_arbiter_mem_wdata,
    output logic [DATA_W-1:0]          o_mem_arbiter_rdata,
    output logic                       o_mem_arbiter_icache_rvalid,
    output logic                       o_mem_arbiter_dcache_rvalid,
    output logic                       o_mem_arbiter_dcache_wnext,
    output logic                       o_mem_arbiter_icache_done,
    output logic                       o_mem_arbiter_dcache_done,
    output logic [$clog2(BEATS)-1:0]   o_mem_arbiter_beat,
    output logic                       o_mem_arbiter_icache_stall,
    output logic                       o_mem_arbiter_dcache_stall
);

    localparam int BW    = $clog2(BEATS);
    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = $clog2(BEATS * BYTES);
    localparam logic [ADDR_W-1:0] LINE_MASK =
        ~((ADDR_W'(1) << OFF_W) - ADDR_W'(1));

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DONE} state_t;

    state_t            state_q, state_d;
    logic [BW-1:0]     beat_q, beat_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              we_q, we_d;
    logic              last_d_q, last_d_d;
    logic              busy_i, busy_d, busy, fin;

    always_ff @(posedge i_mem_arbiter_clk or negedge i_mem_arbiter_rst_n) begin
        if (!i_mem_arbiter_rst_n) begin
            state_q  <= IDLE;
            beat_q   <= '0;
            base_q   <= '0;
            we_q     <= 1'b0;
            last_d_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            base_q   <= base_d;
            we_q     <= we_d;
            last_d_q <= last_d_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        base_d   = base_q;
        we_d     = we_q;
        last_d_d = last_d_q;
        unique case (state_q)
            IDLE: begin
                // D wins a tie unless it owned the previous transfer.
                if (i_mem_arbiter_dcache_req &&
                    !(i_mem_arbiter_icache_req && last_d_q)) begin
                    state_d  = BUSY_D;
                    base_d   = i_mem_arbiter_dcache_addr & LINE_MASK;
                    we_d     = i_mem_arbiter_dcache_we;
                    last_d_d = 1'b1;
                    beat_d   = '0;
                end else if (i_mem_arbiter_icache_req) begin
                    state_d  = BUSY_I;
                    base_d   = i_mem_arbiter_icache_addr & LINE_MASK;
                    we_d     = 1'b0;
                    last_d_d = 1'b0;
                    beat_d   = '0;
                end
            end
            BUSY_I, BUSY_D: begin
                if (i_mem_arbiter_mem_ack) begin
                    if (fin) state_d = DONE;
                    else     beat_d  = beat_q + BW'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy_i = (state_q == BUSY_I);
    assign busy_d = (state_q == BUSY_D);
    assign busy   = busy_i | busy_d;
    assign fin    = busy & i_mem_arbiter_mem_ack &
                    (beat_q == BW'(BEATS - 1));

    assign o_mem_arbiter_mem_req   = busy;
    assign o_mem_arbiter_mem_we    = busy & we_q;
    assign o_mem_arbiter_mem_addr  = busy ?
        base_q + ADDR_W'(beat_q) * ADDR_W'(BYTES) : '0;
    assign o_mem_arbiter_mem_wdata = busy ? i_mem_arbiter_dcache_wdata : '0;
    assign o_mem_arbiter_rdata     = busy ? i_mem_arbiter_mem_rdata : '0;
    assign o_mem_arbiter_beat      = beat_q;

    assign o_mem_arbiter_icache_rvalid = busy_i & i_mem_arbiter_mem_ack & ~we_q;
    assign o_mem_arbiter_dcache_rvalid = busy_d & i_mem_arbiter_mem_ack & ~we_q;
    assign o_mem_arbiter_dcache_wnext  = busy_d & i_mem_arbiter_mem_ack & we_q;
    assign o_mem_arbiter_icache_done   = busy_i & fin;
    assign o_mem_arbiter_dcache_done   = busy_d & fin;

    assign o_mem_arbiter_icache_stall =
        i_mem_arbiter_icache_req & ~o_mem_arbiter_icache_done;
    assign o_mem_arbiter_dcache_stall =
        i_mem_arbiter_dcache_req & ~o_mem_arbiter_dcache_done;

endmodule

// File: tb/tb_riscv_core_mem_arbiter.sv
// Directed bench for riscv_core_mem_arbiter.
// A transfer-level model is compared on every falling edge.
module tb_riscv_core_mem_arbiter;

    localparam int BEATS = 4;
    localparam logic [63:0] LMASK = ~64'h1f;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ireq, dreq, dwe, ack;
    logic [63:0] iaddr, daddr, dwdata, mrdata;
    logic        mreq, mwe, irv, drv, wnext, idone, ddone, istall, dstall;
    logic [63:0] maddr, mwdata, rdata;
    logic [1:0]  beat;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    riscv_core_mem_arbiter dut (
        .i_mem_arbiter_clk          (clk),
        .i_mem_arbiter_rst_n        (rst_n),
        .i_mem_arbiter_icache_req   (ireq),
        .i_mem_arbiter_icache_addr  (iaddr),
        .i_mem_arbiter_dcache_req   (dreq),
        .i_mem_arbiter_dcache_we    (dwe),
        .i_mem_arbiter_dcache_addr  (daddr),
        .i_mem_arbiter_dcache_wdata (dwdata),
        .i_mem_arbiter_mem_ack      (ack),
        .i_mem_arbiter_mem_rdata    (mrdata),
        .o_mem_arbiter_mem_req      (mreq),
        .o_mem_arbiter_mem_we       (mwe),
        .o_mem_arbiter_mem_addr     (maddr),
        .o_mem_arbiter_mem_wdata    (mwdata),
        .o_mem_arbiter_rdata        (rdata),
        .o_mem_arbiter_icache_rvalid(irv),
        .o_mem_arbiter_dcache_rvalid(drv),
        .o_mem_arbiter_dcache_wnext (wnext),
        .o_mem_arbiter_icache_done  (idone),
        .o_mem_arbiter_dcache_done  (ddone),
        .o_mem_arbiter_beat         (beat),
        .o_mem_arbiter_icache_stall (istall),
        .o_mem_arbiter_dcache_stall (dstall)
    );

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk64(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: owner 0=none 1=I 2=D, beats already acked, one-cycle cooldown.
    int          m_owner = 0;
    int          m_beats = 0;
    bit          m_cool = 1'b0;
    bit          m_last_d = 1'b0;
    bit          m_we = 1'b0;
    logic [63:0] m_base = 64'h0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owner  <= 0;
            m_beats  <= 0;
            m_cool   <= 1'b0;
            m_last_d <= 1'b0;
            m_we     <= 1'b0;
            m_base   <= 64'h0;
        end else if (m_cool) begin
            m_cool <= 1'b0;
        end else if (m_owner != 0) begin
            if (ack) begin
                if (m_beats == BEATS - 1) begin
                    m_owner <= 0;
                    m_cool  <= 1'b1;
                end else begin
                    m_beats <= m_beats + 1;
                end
            end
        end else if (dreq && !(ireq && m_last_d)) begin
            m_owner  <= 2;
            m_base   <= daddr & LMASK;
            m_we     <= dwe;
            m_beats  <= 0;
            m_last_d <= 1'b1;
        end else if (ireq) begin
            m_owner  <= 1;
            m_base   <= iaddr & LMASK;
            m_we     <= 1'b0;
            m_beats  <= 0;
            m_last_d <= 1'b0;
        end
    end

    always @(negedge clk) begin
        logic busy, isi, isd, fin;
        logic [63:0] ea;
        busy = (m_owner != 0);
        isi  = (m_owner == 1);
        isd  = (m_owner == 2);
        fin  = busy && ack && (m_beats == BEATS - 1);
        ea   = busy ? m_base + 64'(m_beats * 8) : 64'h0;
        chk1("mem_req", mreq, busy);
        chk1("mem_we", mwe, busy && m_we);
        chk64("mem_addr", maddr, ea);
        chk64("mem_wdata", mwdata, busy ? dwdata : 64'h0);
        chk64("rdata", rdata, busy ? mrdata : 64'h0);
        chk1("i_rvalid", irv, isi && ack);
        chk1("d_rvalid", drv, isd && ack && !m_we);
        chk1("wnext", wnext, isd && ack && m_we);
        chk1("i_done", idone, isi && fin);
        chk1("d_done", ddone, isd && fin);
        chk1("i_stall", istall, ireq && !(isi && fin));
        chk1("d_stall", dstall, dreq && !(isd && fin));
        if (busy) chk64("beat", 64'(beat), 64'(m_beats));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int wcnt;

    initial begin
        ireq = 0; iaddr = 0; dreq = 0; dwe = 0; daddr = 0;
        dwdata = 0; ack = 0; mrdata = 0;
        repeat (2) step();
        chk1("rst_req", mreq, 1'b0);
        chk64("rst_beat", 64'(beat), 64'h0);
        rst_n = 1;

        // I-cache refill, ack every cycle
        step();
        ireq = 1; iaddr = 64'h1008; ack = 1;
        @(negedge clk);
        chk1("s1_idle_req", mreq, 1'b0);
        chk1("s1_stall", istall, 1'b1);
        for (int k = 0; k < 4; k++) begin
            step();
            mrdata = 64'hA0 + 64'(k);
            @(negedge clk);
            chk64("s1_addr", maddr, 64'h1000 + 64'(k * 8));
            chk1("s1_done", idone, k == 3);
        end
        step();
        ireq = 0; ack = 0;
        @(negedge clk);
        chk1("s1_done_state_req", mreq, 1'b0);
        repeat (2) step();

        // Simultaneous requests after reset
        rst_n = 0;
        step();
        rst_n = 1;
        ireq = 1; iaddr = 64'h5000; dreq = 1; dwe = 0;
        daddr = 64'h2010; ack = 1;
        step();
        @(negedge clk);
        chk1("s2_d_first", drv, 1'b1);
        chk1("s2_i_not", irv, 1'b0);
        chk64("s2_d_addr", maddr, 64'h2000);
        repeat (3) step();
        @(negedge clk);
        chk1("s2_d_done", ddone, 1'b1);
        step();
        dreq = 0;
        @(negedge clk);
        chk1("s2_done_req", mreq, 1'b0);
        step();
        @(negedge clk);
        chk1("s2_idle_req", mreq, 1'b0);
        step();
        @(negedge clk);
        chk1("s2_i_second", irv, 1'b1);
        chk64("s2_i_addr", maddr, 64'h5000);
        repeat (3) step();
        step();
        dreq = 1; daddr = 64'h6000;
        @(negedge clk);
        chk1("s2_no_grant_done", mreq, 1'b0);
        repeat (2) step();
        @(negedge clk);
        chk1("s2_d_again", drv, 1'b1);
        chk64("s2_d2_addr", maddr, 64'h6000);
        repeat (3) step();
        step();
        dreq = 0; ireq = 0; ack = 0;
        repeat (2) step();

        // D-cache writeback, ack on alternate cycles
        dreq = 1; dwe = 1; daddr = 64'h3000; dwdata = 64'hD0;
        wcnt = 0;
        for (int c = 0; c < 8; c++) begin
            step();
            ack = c[0];
            dwdata = 64'hD0 + 64'(wcnt);
            @(negedge clk);
            chk1("s3_we", mwe, 1'b1);
            chk64("s3_beat_hold", 64'(beat), 64'(c >> 1));
            chk1("s3_done", ddone, c == 7);
            if (wnext) wcnt++;
        end
        step();
        dreq = 0; dwe = 0; ack = 0;
        chk64("s3_wnext_count", 64'(wcnt), 64'd4);
        step();

        // Reset during beat 2 of an I refill
        ireq = 1; iaddr = 64'h4010; ack = 1;
        repeat (3) step();
        chk64("s4_pre_beat", 64'(beat), 64'd2);
        #2 rst_n = 0;
        #1;
        chk1("s4_rst_req", mreq, 1'b0);
        chk1("s4_rst_done", idone, 1'b0);
        chk64("s4_rst_beat", 64'(beat), 64'h0);
        step();
        rst_n = 1;
        @(negedge clk);
        chk1("s4_idle_req", mreq, 1'b0);
        step();
        @(negedge clk);
        chk1("s4_restart_req", mreq, 1'b1);
        chk64("s4_restart_beat", 64'(beat), 64'h0);
        chk64("s4_restart_addr", maddr, 64'h4000);
        repeat (3) step();
        step();
        ireq = 0; ack = 0;
        repeat (2) step();

        // I request held through DONE
        ireq = 1; iaddr = 64'h7000; ack = 1;
        repeat (4) step();
        step();
        @(negedge clk);
        chk1("s5_done_guard", mreq, 1'b0);
        step();
        @(negedge clk);
        chk1("s5_idle_req", mreq, 1'b0);
        step();
        @(negedge clk);
        chk1("s5_regrant", mreq, 1'b1);
        chk64("s5_addr", maddr, 64'h7000);
        repeat (3) step();
        step();
        ireq = 0; ack = 0;
        repeat (2) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
